// File: rtl/mdu_ctrl_pkg.sv
// Shared types and op decode for the multiply/divide sequencer.
// The accumulate ops (MADD/MADDU/MSUB/MSUBU) are decoded as valid only when MDU_MADD_EN is defined.
package mdu_ctrl_pkg;

  localparam int MDU_DIV_ITER = 32;
  localparam int CNT_W        = 6;

  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } mdu_op_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  typedef struct packed {
    logic valid;
    logic is_div;
    logic is_signed;
    logic acc;
    logic sub;
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(mdu_op_t op);
    mdu_dec_t d;
    d = '0;
    case (op)
      OP_MULT:  begin d.valid = 1'b1; d.is_signed = 1'b1; end
      OP_MULTU: d.valid = 1'b1;
      OP_DIV:   begin d.valid = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
      OP_DIVU:  begin d.valid = 1'b1; d.is_div = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin d.valid = 1'b1; d.is_signed = 1'b1; d.acc = 1'b1; end
      OP_MADDU: begin d.valid = 1'b1; d.acc = 1'b1; end
      OP_MSUB:  begin d.valid = 1'b1; d.is_signed = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
      OP_MSUBU: begin d.valid = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU handshake: operation request, flush, stall and HI/LO write port.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic        start;
  mdu_op_t     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [63:0] hilo_in;
  logic        flush;
  logic        stall_o;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (output start, op, src_a, src_b, hilo_in, flush,
                  input  stall_o, hi_we, lo_we, hi_o, lo_o);
  modport slave  (input  start, op, src_a, src_b, hilo_in, flush,
                  output stall_o, hi_we, lo_we, hi_o, lo_o);
endinterface

// File: rtl/mdu_ctrl_div_radix2_core.sv
// Iterative unsigned 32/32 restoring divider: start loads operands, each step retires one quotient bit.
module div_radix2_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] dvs_q;
  logic [32:0] partial;
  logic [32:0] diff;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    partial = {remainder, quotient[31]};
    diff    = partial - {1'b0, dvs_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs_q     <= '0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs_q     <= divisor;
    end else if (step) begin
      if (!diff[32]) begin
        remainder <= diff[31:0];
        quotient  <= {quotient[30:0], 1'b1};
      end else begin
        remainder <= partial[31:0];
        quotient  <= {quotient[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning the HI/LO write port; stalls EX while busy, aborts on flush.
// Optional MDU_MADD_EN enables the accumulate ops (hilo_in +/- product).
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = MDU_DIV_ITER
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  mdu_state_t       state, state_nxt;
  mdu_dec_t         dec, dec_q;
  logic             accept;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q, b_q, dvd_mag, dvs_mag;
  logic [31:0]      quotient, remainder, hi_q, lo_q;
  logic             q_neg, r_neg;
  logic [63:0]      a_ext, b_ext, prod_q, acc_q, mul_res, div_res, res;

  assign dec     = mdu_decode(bus.op);
  assign accept  = (state == IDLE) && bus.start && dec.valid && !bus.flush;
  assign dvd_mag = (dec.is_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign dvs_mag = (dec.is_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // Low 64 bits of the 33x33 product equal the product of the 64-bit extensions.
  assign a_ext = {{32{dec_q.is_signed & a_q[31]}}, a_q};
  assign b_ext = {{32{dec_q.is_signed & b_q[31]}}, b_q};

  div_radix2_core u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && dec.is_div),
    .step      (state == DIV),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = dec.is_div ? DIV : MUL;
        MUL:  if (cnt == CNT_W'(MUL_LAT - 1))  state_nxt = DONE;
        DIV:  if (cnt == CNT_W'(DIV_ITER - 1)) state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      dec_q  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      prod_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        a_q   <= bus.src_a;
        b_q   <= bus.src_b;
        dec_q <= dec;
        q_neg <= dec.is_signed && (bus.src_a[31] ^ bus.src_b[31]);
        r_neg <= dec.is_signed && bus.src_a[31];
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt + 1'b1;
      end
      if (state == MUL) prod_q <= a_ext * b_ext;
      if (state == DONE && !bus.flush) begin
        hi_q <= res[63:32];
        lo_q <= res[31:0];
      end
    end
  end

`ifdef MDU_MADD_EN
  always_ff @(posedge clk) begin
    if (!rst)        acc_q <= '0;
    else if (accept) acc_q <= bus.hilo_in;
  end
`else
  assign acc_q = '0;
`endif

  always_comb begin
    mul_res = prod_q;
    if (dec_q.acc) mul_res = dec_q.sub ? (acc_q - prod_q) : (acc_q + prod_q);
    div_res = {r_neg ? -remainder : remainder, q_neg ? -quotient : quotient};
    res     = dec_q.is_div ? div_res : mul_res;
  end

  always_comb begin
    bus.stall_o = !bus.flush && (accept || state == MUL || state == DIV);
    bus.hi_we   = (state == DONE) && !bus.flush;
    bus.lo_we   = (state == DONE) && !bus.flush;
    bus.hi_o    = (state == DONE) ? res[63:32] : hi_q;
    bus.lo_o    = (state == DONE) ? res[31:0]  : lo_q;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer in the EX stage of the MIPS pipeline, owning all writes to the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from EX and stalls the pipeline while busy.
- Runs a pipelined multiply or a 32-iteration radix-2 restoring divide.
- Issues a single-cycle HI/LO write with the result.
- Flushes cleanly on exception.

Parameters:
MUL_LAT, 2, cycles spent in MUL state (1..4); models a pipelined multiplier.
DIV_ITER, 32, divider iterations; fixed at 32, exposed for bench shortening only.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset
start  input  1  EX holds a mul/div op; held until stall_o drops
op  input  3  mdu_op_t: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
src_a  input  32  rs operand
src_b  input  32  rt operand
hilo_in  input  64  current {hi,lo} from forwarding path; used only for accumulate ops
flush  input  1  exception/eret flush; abort without write
stall_o  output  1  pipeline stall request
hi_we  output  1  HI write enable (one-cycle pulse)
lo_we  output  1  LO write enable (one-cycle pulse)
hi_o  output  32  HI write data
lo_o  output  32  LO write data

Behaviour:
- Reset values: state IDLE; stall_o=0, hi_we=0, lo_we=0, hi_o=0, lo_o=0. Internal operand, counter and remainder registers are cleared.
- States: IDLE, MUL, DIV, DONE (mdu_state_t).
- IDLE:
  - start=1 with a valid op: latch operands and op, zero the counter, go to MUL (ops 0,1,4-7) or DIV (ops 2,3).
  - Invalid op: stay in IDLE, no stall.
- stall_o:
  - Combinational: (IDLE && start && valid op && !flush) || MUL || DIV.
  - Low in DONE, which releases EX.
- MUL:
  - Counter increments each cycle; go to DONE when count==MUL_LAT-1.
  - Product is a full 64-bit result. Signed ops sign-extend both operands to 33 bits; unsigned ops zero-extend.
- DIV:
  - Operands are converted to magnitudes (signed op) at launch.
  - One restoring step per cycle; go to DONE after DIV_ITER cycles.
- DONE, one cycle:
  - hi_we=lo_we=1.
  - DIV: lo_o=quotient, hi_o=remainder. Quotient is negated when operand signs differ (signed op). Remainder takes the dividend's sign.
  - MUL: {hi_o,lo_o}=product.
  - Unconditionally return to IDLE. start is ignored in DONE because it is the completing instruction still held. Back-to-back ops therefore launch one cycle later from IDLE.
- Latency:
  - Acceptance edge at cycle T. MULT writes at T+MUL_LAT (in DONE cycle), so stall_o is high for MUL_LAT+1 cycles incl. T.
  - DIV writes in cycle T+DIV_ITER+1.
- Divide by zero: no trap. lo_o=32'hFFFF_FFFF and hi_o=dividend (raw restoring result), with the sign fixup still applied for DIV.
- Corner case: DIV 0x8000_0000 / -1 gives lo=0x8000_0000, hi=0.
- flush:
  - In any state, or together with start in IDLE: next state IDLE, no write pulse, stall_o forced 0 in the same cycle.
  - flush wins over DONE: no write that cycle.
- Reset mid-operation: immediate return to IDLE next edge, no write.
- The hi_o/lo_o registers hold their last value outside DONE. hi_we/lo_we are the only qualifiers.

Optional Feature:
MDU_MADD_EN
- Defined:
  - Ops 4-7 are valid. hilo_in is sampled at launch.
  - DONE writes hilo_in ± product (64-bit wrap-around): MADD/MADDU add, MSUB/MSUBU subtract. Signedness follows the op.
- Undefined:
  - Ops 4-7 are invalid: no launch, no stall, no write.
  - hilo_in is unused.

Decomposition:
- my_mips.svh holds mdu_op_t (3-bit enum), mdu_state_t, and the constant MDU_DIV_ITER=32.
- The op-to-valid/signed/accumulate decode function is shared there so the decoder can reuse it.
- One sub-module, div_radix2_core: iterative unsigned 32/32 restoring divider. It has start/step inputs and quotient/remainder outputs; the sign fixup stays in mdu_ctrl.

Test Plan:
- MULT -3 × 5, MUL_LAT=2 → stall_o high 3 cycles, then one-cycle hi_we=lo_we=1 with hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV -7 / 2 → write at T+33: lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1). DIVU 7/0 → lo=0xFFFF_FFFF, hi=7.
- DIVU 100/7 with flush asserted at cycle T+10 → no hi_we/lo_we, stall_o drops the same cycle, next MULTU 2×3 completes normally with lo=6.
- Back-to-back MULTU with start held through DONE → exactly one write per instruction; second launches from IDLE the cycle after DONE.
- (MDU_MADD_EN) hilo_in=64'h1, MADD 2×3 → {hi,lo}=64'h7. Without the macro, op=4 gives no stall and no write.
